// File: rtl/store_data_packer_if.sv
// Store request and memory write channel between the pipeline, store_data_packer and memory.
// slave is the packer's view; master is the pipeline plus memory side driving it.
interface store_data_packer_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [XLEN-1:0]   st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_be;
  logic              st_done;
  logic              st_err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_gnt, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_gnt, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err
  );
endinterface

// File: rtl/store_data_packer.sv
// Packs SB/SH/SW stores into word-aligned lane-shifted writes, splitting misaligned ones into two beats.
// Aligned store: accept T, mem_req T+1, st_done T+3 at best; st_ready low while a store is in flight, beats held until mem_gnt.
module store_data_packer #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  store_data_packer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [2*XLEN-1:0] wide;
    logic [7:0]        be8;
  } req_t;

  state_t          state_q, state_n;
  req_t            req_q, req_n;
  logic            ready_q;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            accept;
  logic            legal;
  logic            need_b1;
  logic            beat_sel;
  logic            mem_req;
  logic [1:0]      off;
  logic [3:0]      mask;
  logic [XLEN-1:0] data_m;

  assign bus.st_ready = ready_q && (state_q == IDLE);
  assign accept       = bus.st_valid && bus.st_ready;
  assign legal        = (bus.st_size != 2'b11);
  assign off          = bus.st_addr[1:0];

  always_comb begin
    mask   = 4'b1111;
    data_m = bus.st_data;
    case (bus.st_size)
      2'b00: begin
        mask   = 4'b0001;
        data_m = {{(XLEN-8){1'b0}}, bus.st_data[7:0]};
      end
      2'b01: begin
        mask   = 4'b0011;
        data_m = {{(XLEN-16){1'b0}}, bus.st_data[15:0]};
      end
      default: begin
        mask   = 4'b1111;
        data_m = bus.st_data;
      end
    endcase
  end

  // Lane-shift into a two-word window; the upper word is the spill into the next aligned word.
  always_comb begin
    req_n.base = {bus.st_addr[ADDR_W-1:2], 2'b00};
    req_n.wide = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
    req_n.be8  = {4'b0000, mask} << off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (accept && legal) begin
      req_q <= req_n;
    end
  end

  assign need_b1 = |req_q.be8[7:4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ready_q <= 1'b1;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // mem_ack is only looked at in the WAIT states, so an early ack during REQ is dropped.
  always_comb begin
    state_n  = state_q;
    mem_req  = 1'b0;
    beat_sel = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) state_n = REQ0;
          else       err_n   = 1'b1;
        end
      end
      REQ0: begin
        mem_req = 1'b1;
        if (bus.mem_gnt) state_n = WAIT0;
      end
      WAIT0: begin
        if (bus.mem_ack) begin
          if (need_b1) begin
            state_n = REQ1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      REQ1: begin
        mem_req  = 1'b1;
        beat_sel = 1'b1;
        if (bus.mem_gnt) state_n = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_ack) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.st_done   = done_q;
  assign bus.st_err    = err_q;
  assign bus.mem_addr  = !mem_req ? '0 :
                         beat_sel ? req_q.base + ADDR_W'(4) : req_q.base;
  assign bus.mem_wdata = !mem_req ? '0 :
                         beat_sel ? req_q.wide[2*XLEN-1:XLEN] : req_q.wide[XLEN-1:0];
  assign bus.mem_be    = !mem_req ? 4'b0000 :
                         beat_sel ? req_q.be8[7:4] : req_q.be8[3:0];

endmodule

// File: tb/tb_store_data_packer.sv
// Directed and random stores through store_data_packer; expected beats come from a per-byte address model.
`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_store_data_packer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_be   [2];
  int          exp_nbeats;

  store_data_packer_if #(.XLEN(32), .ADDR_W(32)) bus ();
  store_data_packer #(.XLEN(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Each stored byte k lands at address addr+k; the word it falls in picks the beat.
  task automatic model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    logic [31:0] base, a;
    int          lane, b;
    base        = addr & ~32'h3;
    exp_addr[0] = base;
    exp_addr[1] = base + 32'd4;
    exp_data[0] = '0;
    exp_data[1] = '0;
    exp_be[0]   = '0;
    exp_be[1]   = '0;
    for (int k = 0; k < (1 << int'(size)); k++) begin
      a    = addr + 32'(k);
      lane = int'(a[1:0]);
      b    = ((a & ~32'h3) == base) ? 0 : 1;
      exp_data[b][8*lane +: 8] = data[8*k +: 8];
      exp_be[b][lane]          = 1'b1;
    end
    exp_nbeats = (exp_be[1] != 4'b0000) ? 2 : 1;
  endtask

  task automatic do_store(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int gnt_wait, input int ack_wait,
                          input bit spurious);
    `CHK({nm, "_ready_in"}, bus.st_ready, 1'b1);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_size  = size;
    step();
    bus.st_valid = 1'b0;
    bus.st_addr  = $urandom;
    bus.st_data  = $urandom;
    if (size == 2'b11) begin
      `CHK({nm, "_err"}, bus.st_err, 1'b1);
      `CHK({nm, "_err_req"}, bus.mem_req, 1'b0);
      `CHK({nm, "_err_ready"}, bus.st_ready, 1'b1);
      `CHK({nm, "_err_done"}, bus.st_done, 1'b0);
      step();
      `CHK({nm, "_err_pulse"}, bus.st_err, 1'b0);
      `CHK({nm, "_err_req2"}, bus.mem_req, 1'b0);
      return;
    end
    model(addr, data, size);
    for (int b = 0; b < exp_nbeats; b++) begin
      for (int i = 0; i <= gnt_wait; i++) begin
        `CHK($sformatf("%s_b%0d_req", nm, b), bus.mem_req, 1'b1);
        `CHK($sformatf("%s_b%0d_addr", nm, b), bus.mem_addr, exp_addr[b]);
        `CHK($sformatf("%s_b%0d_wdata", nm, b), bus.mem_wdata, exp_data[b]);
        `CHK($sformatf("%s_b%0d_be", nm, b), bus.mem_be, exp_be[b]);
        `CHK($sformatf("%s_b%0d_busy", nm, b), bus.st_ready, 1'b0);
        if (i < gnt_wait) begin
          bus.mem_gnt = 1'b0;
          bus.mem_ack = spurious;
          step();
        end
      end
      bus.mem_gnt = 1'b1;
      bus.mem_ack = 1'b0;
      step();
      bus.mem_gnt = 1'b0;
      for (int i = 0; i <= ack_wait; i++) begin
        `CHK($sformatf("%s_b%0d_wait_req", nm, b), bus.mem_req, 1'b0);
        `CHK($sformatf("%s_b%0d_wait_be", nm, b), bus.mem_be, 4'b0000);
        `CHK($sformatf("%s_b%0d_wait_done", nm, b), bus.st_done, 1'b0);
        if (i < ack_wait) step();
      end
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
    end
    `CHK({nm, "_done"}, bus.st_done, 1'b1);
    `CHK({nm, "_done_ready"}, bus.st_ready, 1'b1);
    `CHK({nm, "_done_req"}, bus.mem_req, 1'b0);
    step();
    `CHK({nm, "_done_pulse"}, bus.st_done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_size  = 2'b00;
    bus.mem_gnt  = 1'b0;
    bus.mem_ack  = 1'b0;

    repeat (3) step();
    tests++;
    if (bus.mem_req !== 1'b0) begin
      fails++;
      $error("FAIL rst_req observed=%0b expected=0", bus.mem_req);
    end
    tests++;
    if (bus.mem_be !== 4'b0000) begin
      fails++;
      $error("FAIL rst_be observed=%0b expected=0000", bus.mem_be);
    end
    `CHK("rst_addr", bus.mem_addr, 32'h0);
    `CHK("rst_wdata", bus.mem_wdata, 32'h0);
    `CHK("rst_done", bus.st_done, 1'b0);
    `CHK("rst_err", bus.st_err, 1'b0);
    tests++;
    if (bus.st_ready !== 1'b0) begin
      fails++;
      $error("FAIL rst_ready observed=%0b expected=0", bus.st_ready);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.st_ready !== 1'b1) begin
      fails++;
      $error("FAIL rel_ready observed=%0b expected=1", bus.st_ready);
    end

    do_store("sb_1003", 32'h0000_1003, 32'hAABBCCDD, 2'b00, 0, 0, 1'b0);
    do_store("sw_2002", 32'h0000_2002, 32'h11223344, 2'b10, 0, 1, 1'b0);
    do_store("sh_3003", 32'h0000_3003, 32'h1234BEEF, 2'b01, 1, 0, 1'b0);
    do_store("sw_4000_stall", 32'h0000_4000, 32'hCAFEF00D, 2'b10, 3, 1, 1'b1);
    do_store("ill_5000", 32'h0000_5000, 32'h01020304, 2'b11, 0, 0, 1'b0);
    do_store("lat_sw", 32'h0000_8000, 32'h55AA33CC, 2'b10, 0, 0, 1'b0);
    do_store("sh_aligned", 32'h0000_9002, 32'hFFFF8001, 2'b01, 0, 0, 1'b0);
    do_store("sw_wrap", 32'hFFFF_FFFE, 32'hDEADBEEF, 2'b10, 1, 1, 1'b1);

    // Reset while the first beat of a misaligned word is outstanding.
    `CHK("rs_ready", bus.st_ready, 1'b1);
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h0000_6001;
    bus.st_data  = 32'h76543210;
    bus.st_size  = 2'b10;
    step();
    bus.st_valid = 1'b0;
    `CHK("rs_req0", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    `CHK("rs_wait0", bus.mem_req, 1'b0);
    rst_n = 1'b0;
    step();
    tests++;
    if (bus.mem_req !== 1'b0) begin
      fails++;
      $error("FAIL rs_req observed=%0b expected=0", bus.mem_req);
    end
    `CHK("rs_be", bus.mem_be, 4'b0000);
    `CHK("rs_addr", bus.mem_addr, 32'h0);
    `CHK("rs_ready_low", bus.st_ready, 1'b0);
    `CHK("rs_done", bus.st_done, 1'b0);
    rst_n = 1'b1;
    step();
    `CHK("rs_ready_rel", bus.st_ready, 1'b1);
    `CHK("rs_no_done", bus.st_done, 1'b0);
    `CHK("rs_no_err", bus.st_err, 1'b0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    `CHK("rs_no_beat1", bus.mem_req, 1'b0);
    tests++;
    if (bus.st_done !== 1'b0) begin
      fails++;
      $error("FAIL rs_no_done2 observed=%0b expected=0", bus.st_done);
    end
    do_store("rs_sb", 32'h0000_7002, 32'h000000A5, 2'b00, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      a  = $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if (n % 5 == 0) a[31:2] = '1;
      do_store($sformatf("rnd%0d", n), a, d, sz,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
